// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
interface serial_addsub_if #(parameter int WIDTH = 8);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's complement adder/subtractor: one full-adder stage, LSB first,
// one bit per clock, result and flags registered on completion.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result;
    logic             carry_out, overflow;
    logic             busy, done, accept;
    logic             x, y, sum, carry_nxt, last;

    always_comb begin
        x         = op_a[cnt[IW-1:0]];
        y         = op_b[cnt[IW-1:0]];
        sum       = x ^ y ^ carry;
        carry_nxt = ((x ^ y) & carry) | (x & y);
        last      = (cnt == CW'(WIDTH - 1));
        sr_nxt    = {sum, sr};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nxt = FINISH;
            end
            FINISH: begin
                done = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            sr        <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.b ^ {WIDTH{bus.mode}};
            carry <= bus.mode;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sr    <= sr_nxt[WIDTH-1:1];
            carry <= carry_nxt;
            cnt   <= cnt + CW'(1);
            if (last) begin
                result    <= sr_nxt;
                carry_out <= carry_nxt;
                // carry still holds the carry into the MSB here
                overflow  <= carry ^ carry_nxt;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result    = result;
    assign bus.carry_out = carry_out;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): vector table, scoreboard queue,
// back-to-back, ignored start, and reset-abort sequences.
module tb_serial_addsub;
    localparam int WIDTH = 8;

    typedef struct {
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       v;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       v;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_edge = 1'b0;
    int   busy_cnt = 0;
    exp_t q[$];

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic m, input logic [7:0] a, input logic [7:0] b);
        exp_t       r;
        logic [7:0] bb;
        logic [8:0] s;
        bb    = m ? ~b : b;
        s     = {1'b0, a} + {1'b0, bb} + {8'd0, m};
        r.res = s[7:0];
        r.c   = s[8];
        r.v   = (a[7] == bb[7]) && (s[7] != a[7]);
        r.due = 0;
        return r;
    endfunction

    task automatic push_exp(input logic [7:0] res, input logic c, input logic v);
        exp_t e;
        e.res = res;
        e.c   = c;
        e.v   = v;
        e.due = cyc + WIDTH + 1;
        q.push_back(e);
    endtask

    task automatic issue(input logic m, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic c, input logic v);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = a;
        bus.b     = b;
        push_exp(res, c, v);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.mode  = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_edge = !rst_n;
        end
    end

    // Output monitor: scoreboard pop on done, latency/busy length, and output stability.
    initial begin
        logic [9:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            else if (!bus.done) busy_cnt = 0;
            if (bus.done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("result", 32'(bus.result), 32'(e.res));
                    check("carry_out", 32'(bus.carry_out), 32'(e.c));
                    check("overflow", 32'(bus.overflow), 32'(e.v));
                    check("done_cycle", 32'(cyc), 32'(e.due));
                    check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
                end
                busy_cnt = 0;
            end else if (!rst_edge && rst_n === 1'b1) begin
                check("outputs_stable", 32'({bus.result, bus.carry_out, bus.overflow}), 32'(prev));
            end
            prev = {bus.result, bus.carry_out, bus.overflow};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        exp_t m;
        logic [7:0] ra, rb;
        logic       rm;

        vecs[0] = '{1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow}), 32'd0);

        // First start on the very first edge with reset released.
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].v);
            drain();
        end

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 1'($urandom);
            m  = model(rm, ra, rb);
            issue(rm, ra, rb, m.res, m.c, m.v);
            drain();
        end

        // Start pulsed mid-operation with other operands must be ignored.
        issue(1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (2) @(negedge clk);

        // Start held through FINISH: second op accepted back-to-back.
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.a     = 8'h7F;
        bus.b     = 8'h01;
        push_exp(8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        check("b2b_first_done", 32'(bus.done), 32'd1);
        bus.mode = 1'b1;
        bus.a    = 8'h80;
        bus.b    = 8'h01;
        push_exp(8'h7F, 1'b1, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Reset in the middle of SHIFT aborts with no done and cleared outputs.
        issue(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        q.delete();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        @(negedge clk);
        check("abort_outputs", 32'({bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow}), 32'd0);
        rst_n = 1'b1;
        issue(1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        drain();

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (SHALL be >= 2).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only when state is IDLE or FINISH.
REQ-005 mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 a  input  WIDTH  operand A, two's complement or unsigned; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while bits are being processed (SHIFT state).
REQ-009 done  output  1  one-cycle pulse, result/flags valid and newly updated.
REQ-010 result  output  WIDTH  sum/difference, registered, held until next done.
REQ-011 carry_out  output  1  final carry out of MSB (subtract: 1 = no borrow, a >= b unsigned).
REQ-012 overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Function
REQ-013 Datapath SHALL be a single 1-bit full-adder stage (sum = x^y^c, carry = (x^y)&c | x&y) plus a carry flip-flop, operating LSB first, one bit per clock.
REQ-014 FSM states SHALL be IDLE, SHIFT, FINISH.
REQ-015 IDLE: start=1 -> latch a, b XOR {WIDTH{mode}}, carry <= mode, bit counter <= 0, go SHIFT; start=0 -> stay IDLE.
REQ-016 SHIFT: each cycle process bit [counter], shift sum bit into result shift register, update carry, increment counter; busy=1.
REQ-017 SHIFT: after bit WIDTH-1 processed, load result/carry_out/overflow output registers and go FINISH.
REQ-018 Bit counter SHALL be $clog2(WIDTH)+1 bits wide and never wrap during an operation.
REQ-019 FINISH: done=1, busy=0 for exactly one cycle; start=1 -> accept new operands as in IDLE and go SHIFT (back-to-back); else go IDLE.
REQ-020 Latency: start sampled at edge k -> done high in cycle following edge k+WIDTH; throughput one result per WIDTH+1 cycles.
REQ-021 start asserted while in SHIFT SHALL be ignored; in-flight operands and mode unaffected by input changes.
REQ-022 result, carry_out, overflow SHALL change only on the edge entering FINISH; stable otherwise.
REQ-023 Result arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force state IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, counter=0, carry=0.
REQ-025 Reset during SHIFT SHALL abort the operation with no done pulse; output registers cleared, not updated with partial result.
REQ-026 start sampled in the same cycle as rst_n=0 SHALL be ignored.
REQ-027 First start SHALL be accepted on the first edge with rst_n=1.

Verification (WIDTH=8)
REQ-028 add 0x3C+0x05 -> done 8 cycles after start edge, result 0x41, carry_out 0, overflow 0; busy high exactly 8 cycles.
REQ-029 add 0x7F+0x01 -> 0x80, carry_out 0, overflow 1; add 0xFF+0x01 -> 0x00, carry_out 1, overflow 0.
REQ-030 sub 0x05-0x07 -> 0xFE, carry_out 0, overflow 0; sub 0x80-0x01 -> 0x7F, carry_out 1, overflow 1.
REQ-031 start pulsed again at cycle 3 of SHIFT with different operands -> ignored, first result delivered unchanged.
REQ-032 start held high through FINISH -> second operation begins immediately, done pulses 9 cycles apart, both results correct.
REQ-033 rst_n=0 at cycle 4 of SHIFT -> no done pulse, all outputs 0 next cycle; next start yields correct fresh result.
